// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register: one word per cycle from zero-wait memory, held address under busywait.
// Decode stall parks a finished fetch in a one-entry buffer (HOLD); an EX redirect flushes IF/ID and refetches.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_read,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        imem_busywait,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid
);

   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pending_target;
   fetch_t      hold_buf;
   logic        resp;
   logic [31:0] target;

   assign target    = redirect_target & ~32'h3;
   assign resp      = (state != HOLD) && !imem_busywait;
   assign imem_read = !reset && (state != HOLD);
   assign imem_addr = pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= FETCH;
         pc             <= RESET_PC;
         pending_target <= 32'h0;
         hold_buf       <= '0;
         if_id_instr    <= BUBBLE_INSTR;
         if_id_pc       <= 32'h0;
         if_id_valid    <= 1'b0;
      end else begin
         // IF/ID register: redirect flushes, stall holds, otherwise load or bubble
         if (redirect) begin
            if_id_instr <= BUBBLE_INSTR;
            if_id_pc    <= 32'h0;
            if_id_valid <= 1'b0;
         end else if (!stall) begin
            if (state == FETCH && resp) begin
               if_id_instr <= imem_instr;
               if_id_pc    <= pc;
               if_id_valid <= 1'b1;
            end else if (state == HOLD) begin
               if_id_instr <= hold_buf.instr;
               if_id_pc    <= hold_buf.pc;
               if_id_valid <= 1'b1;
            end else begin
               if_id_instr <= BUBBLE_INSTR;
               if_id_pc    <= 32'h0;
               if_id_valid <= 1'b0;
            end
         end

         case (state)
            FETCH: begin
               if (resp) begin
                  if (redirect) begin
                     pc <= target;
                  end else begin
                     pc <= pc + 32'd4;
                     if (stall) begin
                        hold_buf.instr <= imem_instr;
                        hold_buf.pc    <= pc;
                        state          <= HOLD;
                     end
                  end
               end else if (redirect) begin
                  pending_target <= target;
                  state          <= DISCARD;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= FETCH;
               end else if (!stall) begin
                  state <= FETCH;
               end
            end
            DISCARD: begin
               // The in-flight word belongs to the squashed path; only the latest target survives
               if (resp) begin
                  pc    <= redirect ? target : pending_target;
                  state <= FETCH;
               end else if (redirect) begin
                  pending_target <= target;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Fetch-stage bench: directed scenarios then random busywait/stall/redirect traffic, checked by a program-order scoreboard.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC     = 32'h0000_0000;
   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        imem_busywait = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;

   int errors = 0;
   int checks = 0;
   int deliveries = 0;

   // Expected program-order stream: head is the next PC decode should receive
   logic [31:0] exp_q[$];

   if_fetch_stage #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(BUBBLE_INSTR)) dut (
      .clock(clock), .reset(reset),
      .imem_read(imem_read), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .imem_busywait(imem_busywait),
      .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
   );

   always #5 clock = ~clock;

   // Memory image: word at A is A|0x13; garbage while busy
   assign imem_instr = imem_busywait ? 32'hDEAD_BEEF : (imem_addr | 32'h13);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic restart_model(input logic [31:0] start_pc);
      exp_q.delete();
      exp_q.push_back(start_pc & ~32'h3);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic bw, input logic st, input logic rd, input logic [31:0] tg);
      imem_busywait   = bw;
      stall           = st;
      redirect        = rd;
      redirect_target = tg;
      if (rd) restart_model(tg);
   endtask

   // Monitor: a word is consumed by decode when valid, not stalled and not being flushed
   logic        prev_pend = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   always @(negedge clock) begin
      if (reset) begin
         prev_pend = 1'b0;
      end else begin
         if (prev_pend) begin
            check("addr_stable", imem_addr, prev_addr);
            check("read_held", {31'b0, imem_read}, 32'h1);
         end
         check("bubble_inv", {31'b0, (if_id_valid == 1'b0) == (if_id_instr == BUBBLE_INSTR)}, 32'h1);
         if (if_id_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: got pc %h expected no delivery", if_id_pc);
            end else begin
               logic [31:0] e_pc;
               e_pc = exp_q.pop_front();
               check("sb_pc", if_id_pc, e_pc);
               check("sb_instr", if_id_instr, e_pc | 32'h13);
               exp_q.push_back(e_pc + 32'd4);
               deliveries++;
            end
         end
         prev_pend = imem_read && imem_busywait;
         prev_addr = imem_addr;
      end
   end

   initial begin
      drive(0, 0, 0, 32'h0);
      restart_model(RESET_PC);
      #1 reset = 1'b1;
      #2;
      check("rst_read", {31'b0, imem_read}, 32'h0);
      check("rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst_instr", if_id_instr, BUBBLE_INSTR);
      check("rst_pc", if_id_pc, 32'h0);
      check("rst_addr", imem_addr, RESET_PC);
      cyc();
      cyc();
      reset = 1'b0;

      // Zero-wait streaming
      for (int k = 0; k < 8; k++) begin
         check("stream_addr", imem_addr, RESET_PC + 32'(4 * k));
         if (k > 0) begin
            check("stream_valid", {31'b0, if_id_valid}, 32'h1);
            check("stream_pc", if_id_pc, RESET_PC + 32'(4 * (k - 1)));
         end
         drive(0, 0, 0, 32'h0);
         cyc();
      end

      // Redirect latency: bubble on the redirect edge, target valid one edge later
      drive(0, 0, 1, 32'h40);
      cyc();
      check("redir_bubble", {31'b0, if_id_valid}, 32'h0);
      check("redir_addr", imem_addr, 32'h40);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("redir_valid", {31'b0, if_id_valid}, 32'h1);
      check("redir_pc", if_id_pc, 32'h40);

      // Busywait 3 cycles at 0x44
      for (int i = 0; i < 3; i++) begin
         check("busy_addr", imem_addr, 32'h44);
         drive(1, 0, 0, 32'h0);
         cyc();
         check("busy_bubble", {31'b0, if_id_valid}, 32'h0);
      end
      check("busy_addr", imem_addr, 32'h44);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("busy_done_pc", if_id_pc, 32'h44);
      check("busy_done_instr", if_id_instr, 32'h57);

      // Redirects during an outstanding fetch: address held, latest target wins
      drive(1, 0, 1, 32'h103);
      cyc();
      check("disc_addr", imem_addr, 32'h48);
      check("disc_read", {31'b0, imem_read}, 32'h1);
      check("disc_bubble", {31'b0, if_id_valid}, 32'h0);
      drive(1, 0, 1, 32'h200);
      cyc();
      check("disc_addr2", imem_addr, 32'h48);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("disc_drop", {31'b0, if_id_valid}, 32'h0);
      check("disc_newaddr", imem_addr, 32'h200);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("disc_pc", if_id_pc, 32'h200);

      // Two-cycle stall parks the next word in HOLD
      drive(0, 1, 0, 32'h0);
      cyc();
      drive(0, 1, 0, 32'h0);
      cyc();
      check("hold_read", {31'b0, imem_read}, 32'h0);
      check("hold_pc", if_id_pc, 32'h200);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("hold_release_pc", if_id_pc, 32'h204);
      check("hold_release_addr", imem_addr, 32'h208);

      // Redirect + stall while in HOLD
      drive(0, 1, 0, 32'h0);
      cyc();
      drive(0, 1, 1, 32'h400);
      cyc();
      check("hold_redir_bubble", {31'b0, if_id_valid}, 32'h0);
      check("hold_redir_addr", imem_addr, 32'h400);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("hold_redir_pc", if_id_pc, 32'h400);

      // PC wrap
      drive(0, 0, 1, 32'hFFFF_FFFE);
      cyc();
      check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("wrap_addr1", imem_addr, 32'h0);
      drive(0, 0, 0, 32'h0);
      cyc();
      check("wrap_pc", if_id_pc, 32'h0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic        bw, st, rd;
         logic [31:0] tg;
         bw = ($urandom_range(0, 99) < 30);
         st = ($urandom_range(0, 99) < 25);
         rd = ($urandom_range(0, 99) < 6);
         tg = $urandom;
         if ($urandom_range(0, 7) == 0) tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         drive(bw, st, rd, tg);
         cyc();
      end

      // Reset while HOLD has a valid instruction presented
      drive(0, 0, 0, 32'h0);
      cyc();
      drive(0, 0, 0, 32'h0);
      cyc();
      drive(0, 1, 0, 32'h0);
      cyc();
      check("pre_rst_valid", {31'b0, if_id_valid}, 32'h1);
      reset = 1'b1;
      restart_model(RESET_PC);
      #1;
      check("rst_hold_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst_hold_instr", if_id_instr, BUBBLE_INSTR);
      cyc();
      reset = 1'b0;
      drive(0, 0, 0, 32'h0);
      cyc();

      // Reset mid-DISCARD; the pending response must be ignored
      drive(1, 0, 1, 32'h500);
      cyc();
      drive(1, 0, 0, 32'h0);
      reset = 1'b1;
      restart_model(RESET_PC);
      #1;
      check("rst_disc_read", {31'b0, imem_read}, 32'h0);
      check("rst_disc_addr", imem_addr, RESET_PC);
      check("rst_disc_pc", if_id_pc, 32'h0);
      drive(0, 0, 0, 32'h0);
      cyc();
      reset = 1'b0;
      check("rst_restart_addr", imem_addr, RESET_PC);
      cyc();
      check("rst_restart_pc", if_id_pc, RESET_PC);
      check("rst_restart_valid", {31'b0, if_id_valid}, 32'h1);
      cyc();
      cyc();

      check("enough_deliveries", {31'b0, deliveries > 500}, 32'h1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage and IF/ID pipeline register feeding the ID-stage decoder. Holds the PC and fetches 32-bit words from the instruction memory over a read/busywait handshake. Presents instruction+PC+valid to decode. Honours decode-side stall and EX-side redirect (taken branch/JAL/JALR); a redirect flushes the IF/ID register.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
BUBBLE_INSTR, 32'h00000000, encoding driven on if_id_instr when invalid (opcode 0000000 → decoder disables reg write/mem ops).

Ports:
clock  in  1  Single clock domain, rising edge.
reset  in  1  Asynchronous, active-high; clears all state immediately.
imem_read  out  1  Fetch request; held high with stable address until imem_busywait low.
imem_addr  out  32  Fetch address, word aligned.
imem_instr  in  32  Fetched word, valid in cycle imem_busywait is low while imem_read high.
imem_busywait  in  1  High while memory busy; low = response this cycle.
stall  in  1  Decode/hazard stall: hold IF/ID register.
redirect  in  1  Taken branch/jump from EX: flush and refetch.
redirect_target  in  32  New PC; bits [1:0] forced to 00.
if_id_instr  out  32  Instruction to decode.
if_id_pc  out  32  PC of if_id_instr.
if_id_valid  out  1  if_id_instr is a real instruction.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=FETCH, imem_read=0 while reset high, if_id_instr=BUBBLE_INSTR, if_id_pc=0, if_id_valid=0, holding buffer empty, pending target=0.
- imem_addr = pc in FETCH, = pc in DISCARD (old address kept stable); imem_read=1 in FETCH and DISCARD, 0 in HOLD.
- IF/ID update priority each edge: redirect > stall > load. redirect → IF/ID = bubble (valid 0, instr BUBBLE_INSTR, pc 0) even if stall. stall and no redirect → IF/ID holds. Otherwise IF/ID loads the instruction available this cycle, else a bubble (never re-issue).
- FETCH:
  - response (busywait=0) and redirect: drop word; pc<=target; stay FETCH.
  - response, no redirect, no stall: IF/ID<={imem_instr, pc, 1}; pc<=pc+4; stay FETCH (back-to-back fetch, 1 instr/cycle with zero-wait memory).
  - response, stall: buffer<={imem_instr, pc}; pc<=pc+4; go HOLD.
  - no response, redirect: pending_target<=target; go DISCARD (address must stay stable).
  - no response, no redirect: stay FETCH, pc unchanged.
- HOLD: no request. redirect → drop buffer, pc<=target, FETCH. stall → remain. else IF/ID<=buffer (valid 1), FETCH.
- DISCARD: wait for busywait=0; further redirects overwrite pending_target (latest wins). On response: word dropped, pc<=pending_target, FETCH; IF/ID bubble unless stalled.
- PC arithmetic modulo 2^32: pc=FFFFFFFC → 00000000.
- Latency: instruction reaches IF/ID on the edge ending its response cycle; redirect-to-first-new-valid = 2 edges with zero-wait memory.
- Reset mid-fetch/HOLD/DISCARD: all state dropped, restart at RESET_PC after deassertion; outstanding response ignored.
- Invariant: if_id_valid=0 ⇔ if_id_instr=BUBBLE_INSTR.

Test Plan:
- Zero-wait memory returning instr=addr|0x13, no stall → IF/ID sequence pc 0,4,8,C each cycle, valid 1, imem_addr increments by 4 per cycle.
- busywait high 3 cycles per fetch → imem_addr held at 0x4 for 4 cycles, IF/ID bubble (instr 0, valid 0) for 3 cycles, then {0x4, instr, 1}.
- stall for 2 cycles during response at pc 0x8 → IF/ID holds pc 0x4 two cycles, imem_read=0 in HOLD, then pc 0x8 presented; no instruction lost or duplicated.
- redirect to 0x103 while busywait high at pc 0x10 → address stays 0x10 until response, word dropped, next imem_addr=0x100, IF/ID bubble on redirect edge; second redirect to 0x200 during DISCARD → next fetch 0x200.
- redirect and stall same cycle in HOLD → IF/ID becomes bubble, buffer dropped, next fetch at target.
- Assert reset mid-DISCARD → outputs immediately zero/bubble, pc restarts at RESET_PC; PC wrap test from 0xFFFFFFFC → next fetch 0x0.
